issue_scoreboard: RTL

//  N-lane in-order issue hazard unit for the superscalar ID stage, successor to the dual-issue hazard logic.

---
 rtl/issue_scoreboard_pkg.sv | 21 ++
 rtl/issue_scoreboard_reg_scoreboard.sv | 29 ++
 rtl/issue_scoreboard.sv | 90 +++++++++
 3 files changed

// File: rtl/issue_scoreboard_pkg.sv
// issue_scoreboard_pkg: shared pipeline-register masks, opcodes and issue defaults
package issue_scoreboard_pkg;
  localparam int NUM_PIPE_MASKS = 3;
  localparam int PIPE_REG_PC = 0;
  localparam int PIPE_REG_IF_ID = 1;
  localparam int PIPE_REG_ID_EX = 2;
  localparam int ISSUE_LANES_DEFAULT = 2;
  localparam int LOAD_LATENCY_DEFAULT = 1;
  typedef logic [NUM_PIPE_MASKS-1:0] pipe_mask_t;
  typedef enum logic [5:0] {
    OP_CODE_RTYPE = 6'h00,
    OP_CODE_J     = 6'h02,
    OP_CODE_BEQ   = 6'h04,
    OP_CODE_ADDI  = 6'h08,
    OP_CODE_LW    = 6'h23,
    OP_CODE_SW    = 6'h2b
  } op_code_e;
  localparam pipe_mask_t MASK_PC   = pipe_mask_t'(1 << PIPE_REG_PC);
  localparam pipe_mask_t MASK_NOP  = pipe_mask_t'(1 << PIPE_REG_ID_EX);
  localparam pipe_mask_t MASK_FULL = pipe_mask_t'((1 << PIPE_REG_PC) | (1 << PIPE_REG_IF_ID) | (1 << PIPE_REG_ID_EX));
endpackage

// File: rtl/issue_scoreboard_reg_scoreboard.sv
// reg_scoreboard: per-register load countdown; set reloads, flush clears, otherwise counts down to zero
module reg_scoreboard
  import issue_scoreboard_pkg::*;
#(
  parameter int NUM_REGS     = 32,
  parameter int CNT_BITS     = 3,
  parameter int LOAD_LATENCY = LOAD_LATENCY_DEFAULT
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  input  logic [NUM_REGS-1:0] set,
  output logic [NUM_REGS-1:0] busy
);
  logic [NUM_REGS-1:0][CNT_BITS-1:0] cnt_q, cnt_d;

  always_comb begin
    busy = '0;
    cnt_d = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      busy[r] = cnt_q[r] != '0;
      cnt_d[r] = flush ? '0 : set[r] ? CNT_BITS'(LOAD_LATENCY) : busy[r] ? cnt_q[r] - CNT_BITS'(1) : '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/issue_scoreboard.sv
// issue_scoreboard: N-lane in-order issue hazard unit; older independent lanes issue while
// the first hazardous lane and everything younger wait behind it.
module issue_scoreboard
  import issue_scoreboard_pkg::*;
#(
  parameter int NUM_LANES    = ISSUE_LANES_DEFAULT,
  parameter int NUM_REGS     = 32,
  parameter int LOAD_LATENCY = LOAD_LATENCY_DEFAULT,
  parameter int CNT_BITS     = 3,
  localparam int ORDER_BITS  = $clog2(NUM_LANES),
  localparam int REG_BITS    = $clog2(NUM_REGS)
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                flush,
  input  logic [ORDER_BITS-1:0]               oldest,
  input  logic [NUM_LANES-1:0]                lane_valid,
  input  logic [NUM_LANES*2-1:0]              lane_src,
  input  logic [NUM_LANES*REG_BITS-1:0]       lane_rs,
  input  logic [NUM_LANES*REG_BITS-1:0]       lane_rt,
  input  logic [NUM_LANES-1:0]                lane_dst_v,
  input  logic [NUM_LANES*REG_BITS-1:0]       lane_dst,
  input  logic [NUM_LANES-1:0]                lane_load,
  output logic [NUM_LANES*NUM_PIPE_MASKS-1:0] stall,
  output logic [NUM_LANES*NUM_PIPE_MASKS-1:0] nop,
  output logic [NUM_LANES-1:0]                clear,
  output logic [NUM_REGS-1:0]                 busy,
  output logic [31:0]                         stall_cnt
);
  logic [NUM_LANES-1:0] h_pos, blk_pos;
  logic [NUM_REGS-1:0] set;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  reg_scoreboard #(
    .NUM_REGS    (NUM_REGS),
    .CNT_BITS    (CNT_BITS),
    .LOAD_LATENCY(LOAD_LATENCY)
  ) u_sb (
    .clk  (clk),
    .rst_n(rst_n),
    .flush(flush),
    .set  (set),
    .busy (busy)
  );

  // h_pos/blk_pos are indexed by program position, outputs by physical lane
  always_comb begin
    logic acc, hz, use_rs, use_rt;
    logic [REG_BITS-1:0] rs, rt, d;
    int l, k;
    h_pos = '0;
    blk_pos = '0;
    set = '0;
    stall = '0;
    nop = '0;
    clear = '0;
    acc = 1'b0;
    for (int p = 0; p < NUM_LANES; p++) begin
      l = (int'(oldest) + p) % NUM_LANES;
      rs = lane_rs[l*REG_BITS +: REG_BITS];
      rt = lane_rt[l*REG_BITS +: REG_BITS];
      use_rs = lane_src[2*l+1];
      use_rt = lane_src[2*l];
      hz = (use_rs && busy[rs]) || (use_rt && busy[rt]);
      for (int q = 0; q < p; q++) begin
        k = (int'(oldest) + q) % NUM_LANES;
        d = lane_dst[k*REG_BITS +: REG_BITS];
        hz = hz || (lane_valid[k] && lane_dst_v[k] && ((use_rs && rs == d) || (use_rt && rt == d)));
      end
      h_pos[p] = lane_valid[l] && hz;
      acc = acc || h_pos[p];
      blk_pos[p] = acc;
    end
    for (int p = 0; p < NUM_LANES; p++) begin
      l = (int'(oldest) + p) % NUM_LANES;
      stall[l*NUM_PIPE_MASKS +: NUM_PIPE_MASKS] = !acc ? '0 : blk_pos[p] ? MASK_FULL : MASK_PC;
      nop[l*NUM_PIPE_MASKS +: NUM_PIPE_MASKS] = (acc && blk_pos[p]) ? MASK_NOP : '0;
      clear[l] = acc && !blk_pos[p];
      if (lane_valid[l] && !blk_pos[p] && lane_load[l] && lane_dst_v[l])
        set[lane_dst[l*REG_BITS +: REG_BITS]] = 1'b1;
    end
    stall_cnt_d = (h_pos[0] && stall_cnt_q != '1) ? stall_cnt_q + 32'd1 : stall_cnt_q;
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) stall_cnt_q <= '0;
    else stall_cnt_q <= stall_cnt_d;

  assign stall_cnt = stall_cnt_q;
endmodule
